// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and helpers for the multi-cycle execute-stage ALU.
package alu_pkg;

   localparam logic [3:0] ADD  = 4'd0;
   localparam logic [3:0] SUB  = 4'd1;
   localparam logic [3:0] SLL  = 4'd2;
   localparam logic [3:0] SRL  = 4'd3;
   localparam logic [3:0] SRA  = 4'd4;
   localparam logic [3:0] AND  = 4'd5;
   localparam logic [3:0] OR   = 4'd6;
   localparam logic [3:0] XOR  = 4'd7;
   localparam logic [3:0] SLT  = 4'd8;
   localparam logic [3:0] SLTU = 4'd9;
   localparam logic [3:0] MUL  = 4'd10;
   localparam logic [3:0] DIVU = 4'd11;
   localparam logic [3:0] REMU = 4'd12;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   function automatic logic is_multicycle(input logic [3:0] op);
      return (op == MUL) || (op == DIVU) || (op == REMU);
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier and restoring divider, one bit per cycle over BITSIZE cycles.
// done pulses in the last iteration cycle with result valid combinationally alongside it.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int BITSIZE = 32
) (
   input  logic               clk,
   input  logic               rstn_i,
   input  logic               flush,
   input  logic               start,
   input  logic [3:0]         op,
   input  logic [BITSIZE-1:0] a,
   input  logic [BITSIZE-1:0] b,
   output logic               done,
   output logic [BITSIZE-1:0] result
);

   localparam int W  = BITSIZE;
   localparam int CW = $clog2(BITSIZE);

   logic          run;
   logic [CW-1:0] cnt;
   logic [3:0]    op_q;
   // MUL: acc=partial product, sh_a=multiplicand, sh_b=multiplier.
   // DIV: acc=remainder, sh_a=dividend shifting into quotient, sh_b=divisor.
   logic [W-1:0]  acc, sh_a, sh_b;
   logic [W-1:0]  acc_nxt, sh_a_nxt, sh_b_nxt;
   logic [W:0]    rem_sh, diff;

   always_comb begin
      rem_sh   = {acc, sh_a[W-1]};
      diff     = rem_sh - {1'b0, sh_b};
      acc_nxt  = acc;
      sh_a_nxt = sh_a;
      sh_b_nxt = sh_b;
      if (op_q == MUL) begin
         acc_nxt  = acc + (sh_b[0] ? sh_a : '0);
         sh_a_nxt = sh_a << 1;
         sh_b_nxt = sh_b >> 1;
      end else if (!diff[W]) begin
         acc_nxt  = diff[W-1:0];
         sh_a_nxt = {sh_a[W-2:0], 1'b1};
      end else begin
         acc_nxt  = rem_sh[W-1:0];
         sh_a_nxt = {sh_a[W-2:0], 1'b0};
      end
   end

   assign done   = run && (cnt == CW'(BITSIZE-1));
   assign result = (op_q == DIVU) ? sh_a_nxt : acc_nxt;

   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         run  <= 1'b0;
         cnt  <= '0;
         op_q <= '0;
         acc  <= '0;
         sh_a <= '0;
         sh_b <= '0;
      end else if (flush) begin
         run <= 1'b0;
         cnt <= '0;
      end else if (start) begin
         run  <= 1'b1;
         cnt  <= '0;
         op_q <= op;
         acc  <= '0;
         sh_a <= a;
         sh_b <= b;
      end else if (run) begin
         acc  <= acc_nxt;
         sh_a <= sh_a_nxt;
         sh_b <= sh_b_nxt;
         if (done) begin
            run <= 1'b0;
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle handshaked execute-stage ALU with registered, back-pressurable results.
// Define ALU_MULDIV_EN to build iterative MUL/DIVU/REMU; otherwise those decode as unknown ops.
module alu_mc
   import alu_pkg::*;
#(
   parameter int BITSIZE = 32
) (
   input  logic               clk,
   input  logic               rstn_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [BITSIZE-1:0] A_i,
   input  logic [BITSIZE-1:0] B_i,
   input  logic [3:0]         operation_i,
   input  logic               flush_i,
   output logic               valid_o,
   input  logic               ready_i,
   output logic [BITSIZE-1:0] R_o,
   output logic               carry_o,
   output logic               overflow_o,
   output logic               zero_o
);

   localparam int W       = BITSIZE;
   localparam int SHAMT_W = $clog2(BITSIZE);

   state_t               state, state_nxt;
   logic                 accept, mc_op, it_done;
   logic [W-1:0]         it_res, r_q, sc_res, b_add;
   logic                 c_q, v_q, sc_c, sc_v;
   logic [W:0]           sum;
   logic [SHAMT_W-1:0]   shamt;

   assign ready_o    = !flush_i && ((state == IDLE) || ((state == DONE) && ready_i));
   assign accept     = valid_i && ready_o;
   assign valid_o    = (state == DONE);
   assign R_o        = r_q;
   assign carry_o    = c_q;
   assign overflow_o = v_q;
   assign zero_o     = (r_q == '0);

`ifdef ALU_MULDIV_EN
   assign mc_op = is_multicycle(operation_i);

   alu_muldiv_iter #(.BITSIZE(BITSIZE)) u_iter (
      .clk    (clk),
      .rstn_i (rstn_i),
      .flush  (flush_i),
      .start  (accept && mc_op),
      .op     (operation_i),
      .a      (A_i),
      .b      (B_i),
      .done   (it_done),
      .result (it_res)
   );
`else
   assign mc_op   = 1'b0;
   assign it_done = 1'b0;
   assign it_res  = '0;
`endif

   // SUB reuses the adder as A + ~B + 1, so one overflow rule covers both.
   always_comb begin
      b_add  = (operation_i == SUB) ? ~B_i : B_i;
      sum    = {1'b0, A_i} + {1'b0, b_add} + (W+1)'(operation_i == SUB);
      shamt  = B_i[SHAMT_W-1:0];
      sc_res = '0;
      sc_c   = 1'b0;
      sc_v   = 1'b0;
      case (operation_i)
         ADD, SUB: begin
            sc_res = sum[W-1:0];
            sc_c   = sum[W];
            sc_v   = (A_i[W-1] == b_add[W-1]) && (sum[W-1] != A_i[W-1]);
         end
         SLL:     sc_res = A_i << shamt;
         SRL:     sc_res = A_i >> shamt;
         SRA:     sc_res = $unsigned($signed(A_i) >>> shamt);
         AND:     sc_res = A_i & B_i;
         OR:      sc_res = A_i | B_i;
         XOR:     sc_res = A_i ^ B_i;
         SLT:     sc_res = W'($signed(A_i) < $signed(B_i));
         SLTU:    sc_res = W'(A_i < B_i);
         default: sc_res = '0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      if (flush_i) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (accept) state_nxt = mc_op ? BUSY : DONE;
            BUSY:    if (it_done) state_nxt = DONE;
            DONE:    if (ready_i) state_nxt = accept ? (mc_op ? BUSY : DONE) : IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) state <= IDLE;
      else         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         r_q <= '0;
         c_q <= 1'b0;
         v_q <= 1'b0;
      end else if (!flush_i) begin
         if (accept && !mc_op) begin
            r_q <= sc_res;
            c_q <= sc_c;
            v_q <= sc_v;
         end else if ((state == BUSY) && it_done) begin
            r_q <= it_res;
            c_q <= 1'b0;
            v_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc (BITSIZE=32): directed vectors queue expectations, a monitor checks transfers.
module tb_alu_mc;
   import alu_pkg::*;

   localparam int W = 32;
`ifdef ALU_MULDIV_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif
   localparam int MC_LAT = MD ? W + 1 : 1;

   logic         clk = 1'b0, rstn_i = 1'b0, valid_i = 1'b0, flush_i = 1'b0, ready_i = 1'b1;
   logic [3:0]   operation_i = ADD;
   logic [W-1:0] A_i = '0, B_i = '0;
   logic         ready_o, valid_o, carry_o, overflow_o, zero_o;
   logic [W-1:0] R_o;

   alu_mc #(.BITSIZE(W)) dut (
      .clk(clk), .rstn_i(rstn_i), .valid_i(valid_i), .ready_o(ready_o),
      .A_i(A_i), .B_i(B_i), .operation_i(operation_i), .flush_i(flush_i),
      .valid_o(valid_o), .ready_i(ready_i), .R_o(R_o), .carry_o(carry_o),
      .overflow_o(overflow_o), .zero_o(zero_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic [W-1:0] r;
      logic         c, v, z;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   xfer_cyc[$];
   int   n_chk = 0, n_fail = 0, cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: a transfer happens at the posedge following a negedge where valid_o && ready_i.
   always @(negedge clk) begin
      if (rstn_i && valid_o && ready_i) begin
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_result: got R_o=%h with nothing expected", R_o);
         end else begin
            mon_e = sb.pop_front();
            chk({mon_e.name, "_R"}, R_o, mon_e.r);
            chk({mon_e.name, "_carry"}, W'(carry_o), W'(mon_e.c));
            chk({mon_e.name, "_ovf"}, W'(overflow_o), W'(mon_e.v));
            chk({mon_e.name, "_zero"}, W'(zero_o), W'(mon_e.z));
         end
         xfer_cyc.push_back(cyc);
      end
   end

   task automatic push(input string name, input logic [W-1:0] r, input logic c, input logic v);
      exp_t e;
      e.name = name; e.r = r; e.c = c; e.v = v; e.z = (r == '0);
      sb.push_back(e);
   endtask

   // Called at posedge+1; returns at posedge+1 after acceptance with operands scrambled.
   task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int w = 0;
      valid_i = 1'b1; operation_i = op; A_i = a; B_i = b;
      @(negedge clk);
      while (!ready_o && w < 200) begin
         w++;
         @(negedge clk);
      end
      if (w >= 200) begin
         n_chk++; n_fail++;
         $display("FAIL accept_timeout: ready_o stayed 0, required 1");
      end
      @(posedge clk); #1;
      valid_i = 1'b0; A_i = 32'hDEADBEEF; B_i = 32'h0BADF00D; operation_i = ADD;
   endtask

   task automatic sc(input string name, input logic [3:0] op, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] r, input logic c, input logic v);
      push(name, r, c, v);
      send(op, a, b);
   endtask

   task automatic lat(input string name, input int exp);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!valid_o && n < 200);
      chk(name, n, exp);
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) begin
         n_chk++; n_fail++;
         $display("FAIL drain_timeout: %0d results pending, required 0", sb.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_valid"}, W'(valid_o), 0);
      chk({tag, "_ready"}, W'(ready_o), 1);
      chk({tag, "_R"}, R_o, 0);
      chk({tag, "_zero"}, W'(zero_o), 1);
      chk({tag, "_carry"}, W'(carry_o), 0);
      chk({tag, "_ovf"}, W'(overflow_o), 0);
   endtask

   initial begin
      #1 chk_reset("rst");
      @(posedge clk); #1 rstn_i = 1'b1;
      @(posedge clk); #1;

      sc("add_ovf", ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1);
      lat("add_lat", 1);
      sc("sub_neg",   SUB, 32'h0,        32'h1, 32'hFFFFFFFF, 1'b0, 1'b0);
      sc("sub_zero",  SUB, 32'h5,        32'h5, 32'h0,        1'b1, 1'b0);
      sc("add_carry", ADD, 32'hFFFFFFFF, 32'h1, 32'h0,        1'b1, 1'b0);
      sc("sub_ovf",   SUB, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b1, 1'b1);
      drain();

      begin
         int n0, n;
         n0 = xfer_cyc.size();
         sc("sra", SRA, 32'h80000000, 32'd4, 32'hF8000000, 1'b0, 1'b0);
         sc("srl", SRL, 32'h80000000, 32'd4, 32'h08000000, 1'b0, 1'b0);
         n = 0;
         while (xfer_cyc.size() < n0 + 2 && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (xfer_cyc.size() >= n0 + 2) chk("b2b_gap", xfer_cyc[n0+1] - xfer_cyc[n0], 1);
         else chk("b2b_xfers", xfer_cyc.size() - n0, 2);
         @(posedge clk); #1;
      end

      sc("sll31",    SLL,  32'h1,        32'd31,       32'h80000000, 1'b0, 1'b0);
      sc("sll_wrap", SLL,  32'h1,        32'h21,       32'h2,        1'b0, 1'b0);
      sc("and",      AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0);
      sc("or",       OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0);
      sc("xor",      XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0);
      sc("slt",      SLT,  32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0);
      sc("sltu",     SLTU, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1'b0);
      sc("unknown",  4'hF, 32'h3,        32'h4,        32'h0,        1'b0, 1'b0);

      sc("mul", MUL, 32'd12345, 32'd678, MD ? 32'd8369910 : 32'd0, 1'b0, 1'b0);
      lat("mul_lat", MC_LAT);
      sc("mul_ff", MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, MD ? 32'd1 : 32'd0, 1'b0, 1'b0);
      sc("divu", DIVU, 32'd100, 32'd7, MD ? 32'd14 : 32'd0, 1'b0, 1'b0);
      sc("remu", REMU, 32'd100, 32'd7, MD ? 32'd2 : 32'd0, 1'b0, 1'b0);
      sc("divu_z", DIVU, 32'd5, 32'd0, MD ? 32'hFFFFFFFF : 32'd0, 1'b0, 1'b0);
      lat("divz_lat", MC_LAT);
      sc("remu_z", REMU, 32'd5, 32'd0, MD ? 32'd5 : 32'd0, 1'b0, 1'b0);
      drain();

      // Back-pressure: result held stable while the consumer stalls.
      ready_i = 1'b0;
      sc("hold_add", ADD, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0);
      repeat (5) begin
         @(negedge clk);
         chk("hold_valid", W'(valid_o), 1);
         chk("hold_R", R_o, 32'd30);
         chk("hold_ready", W'(ready_o), 0);
      end
      @(posedge clk); #1 ready_i = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_idle_valid", W'(valid_o), 0);
      chk("hold_idle_ready", W'(ready_o), 1);
      @(posedge clk); #1;

      // Flush on BUSY cycle 10 of a divide, with an op offered in the same cycle.
      if (!MD) push("divu_noiter", 32'd0, 1'b0, 1'b0);
      send(DIVU, 32'd100, 32'd7);
      repeat (9) begin @(posedge clk); #1; end
      flush_i = 1'b1; valid_i = 1'b1; operation_i = ADD; A_i = 32'd1; B_i = 32'd1;
      @(negedge clk);
      chk("flush_ready", W'(ready_o), 0);
      @(posedge clk); #1 flush_i = 1'b0; valid_i = 1'b0;
      @(negedge clk);
      chk("flush_idle_ready", W'(ready_o), 1);
      chk("flush_idle_valid", W'(valid_o), 0);
      begin
         logic seen;
         seen = 1'b0;
         repeat (40) begin
            @(negedge clk);
            if (valid_o) seen = 1'b1;
         end
         chk("flush_no_valid", W'(seen), 0);
      end
      @(posedge clk); #1;

      // Reset in the middle of a multiply.
      ready_i = 1'b0;
      send(MUL, 32'd9, 32'd9);
      repeat (5) begin @(posedge clk); #1; end
      rstn_i = 1'b0;
      #1 chk_reset("midrst");
      @(posedge clk); #1 rstn_i = 1'b1; ready_i = 1'b1;
      @(negedge clk);
      chk("midrst_after_valid", W'(valid_o), 0);
      @(posedge clk); #1;

      sc("recover_add", ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);
      drain();
      chk("sb_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_chk++; n_fail++;
      $display("FAIL watchdog: test did not complete within time limit");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
